// File: rtl/boreal_fifo_pkg.sv
// Shared helpers for the Boreal CDC FIFO: Gray-code conversion, default
// synchroniser depth and pointer/level width.
package boreal_fifo_pkg;

  // Default number of flops in each Gray-pointer synchroniser.
  localparam int DEF_SYNC_STAGES = 2;

  // Widest pointer supported (ADDR_WIDTH up to 8, plus the wrap bit).
  // The conversions below run at this width. Callers zero-extend narrower
  // pointers and truncate the result. Leading zeros pass through both
  // conversions unchanged, so this is exact for any narrower width.
  localparam int PTR_MAX_W = 9;

  // Width of a pointer or fill level: one extra bit distinguishes full from empty.
  function automatic int lvl_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/boreal_cdc_fifo_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering a new clock domain.
module boreal_gray_sync
  import boreal_fifo_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the foreign Gray pointer through STAGES destination-clock flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/boreal_cdc_fifo.sv
// Dual-clock Gray-pointer FIFO between the SPI ingestion domain (wr_clk) and
// the Active Inference domain (rd_clk). It provides fill levels in both
// domains, almost-full/empty flags, a registered read port with a valid
// strobe, and sticky overflow/underflow flags.
// Optional: define BOREAL_CDC_FIFO_PARITY_EN to add an even-parity column and
// the rd_parity_err output.
module boreal_cdc_fifo
  import boreal_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 792,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow,
  input  logic                  wr_clr_err,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow,
`ifdef BOREAL_CDC_FIFO_PARITY_EN
  output logic                  rd_parity_err,
`endif
  input  logic                  rd_clr_err
);

  localparam int PW    = lvl_w(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);
`ifdef BOREAL_CDC_FIFO_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 8) begin : g_bad_aw
    $error("boreal_cdc_fifo: ADDR_WIDTH must be 2..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_ss
    $error("boreal_cdc_fifo: SYNC_STAGES must be 2..4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("boreal_cdc_fifo: AF_THRESH must be 1..2**ADDR_WIDTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("boreal_cdc_fifo: AE_THRESH must be 0..2**ADDR_WIDTH-1");
  end

  // Storage is never reset: contents are discarded by pointer reset.
  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;

  // Write-domain state.
  logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
  logic [PW-1:0] wr_level_q, wr_level_d;
  logic [PW-1:0] rd_gray_sync;
  logic          full_q, full_d, af_q, ovf_q, ovf_d, wr_push;

  // Read-domain state.
  logic [PW-1:0]         rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
  logic [PW-1:0]         rd_level_q, rd_level_d;
  logic [PW-1:0]         wr_gray_sync;
  logic                  empty_q, empty_d, ae_q, unf_q, unf_d, rd_pop, rd_valid_q;
  logic [DATA_WIDTH-1:0] dout_q;

  boreal_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd2wr_sync (
    .clk_i  (wr_clk),
    .rst_ni (wr_rst_n),
    .d_i    (rd_gray_q),
    .q_o    (rd_gray_sync)
  );

  boreal_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr2rd_sync (
    .clk_i  (rd_clk),
    .rst_ni (rd_rst_n),
    .d_i    (wr_gray_q),
    .q_o    (wr_gray_sync)
  );

`ifdef BOREAL_CDC_FIFO_PARITY_EN
  assign wr_word = {^din, din};
`else
  assign wr_word = din;
`endif
  assign rd_word = mem_q[rd_bin_q[ADDR_WIDTH-1:0]];

  // ---- write domain ----
  // Next write pointer, full detection, pessimistic level and overflow flag.
  always_comb begin
    wr_push    = wr_en && !full_q;
    wr_bin_d   = wr_bin_q + PW'(wr_push);
    wr_gray_d  = PW'(bin2gray(PTR_MAX_W'(wr_bin_d)));
    // Full: writer is exactly one lap ahead (top two Gray bits inverted).
    full_d     = (wr_gray_d == {~rd_gray_sync[PW-1:PW-2], rd_gray_sync[PW-3:0]});
    // The synchronised read pointer lags, so this level never under-reports.
    wr_level_d = wr_bin_d - PW'(gray2bin(PTR_MAX_W'(rd_gray_sync)));
    // A fresh overflow beats a simultaneous clear.
    ovf_d      = (wr_en && full_q) ? 1'b1 : (wr_clr_err ? 1'b0 : ovf_q);
  end

  // Write-domain registers; almost_full trails wr_level by one cycle.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      wr_level_q <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      wr_level_q <= wr_level_d;
      full_q     <= full_d;
      af_q       <= (wr_level_q >= AF_LIM);
      ovf_q      <= ovf_d;
    end
  end

  // Store accepted write data.
  always_ff @(posedge wr_clk) begin
    if (wr_push) mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= wr_word;
  end

  // ---- read domain ----
  // Next read pointer, empty detection, optimistic-free level and underflow flag.
  always_comb begin
    rd_pop     = rd_en && !empty_q;
    rd_bin_d   = rd_bin_q + PW'(rd_pop);
    rd_gray_d  = PW'(bin2gray(PTR_MAX_W'(rd_bin_d)));
    empty_d    = (rd_gray_d == wr_gray_sync);
    // The synchronised write pointer lags, so this level never over-reports.
    rd_level_d = PW'(gray2bin(PTR_MAX_W'(wr_gray_sync))) - rd_bin_d;
    // A fresh underflow beats a simultaneous clear.
    unf_d      = (rd_en && empty_q) ? 1'b1 : (rd_clr_err ? 1'b0 : unf_q);
  end

  // Read-domain registers: pointer, flags, and the one-cycle-latency data port.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q      <= '0;
      rd_gray_q     <= '0;
      rd_level_q    <= '0;
      empty_q       <= 1'b1;
      ae_q          <= 1'b1;
      unf_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      dout_q        <= '0;
`ifdef BOREAL_CDC_FIFO_PARITY_EN
      rd_parity_err <= 1'b0;
`endif
    end else begin
      rd_bin_q      <= rd_bin_d;
      rd_gray_q     <= rd_gray_d;
      rd_level_q    <= rd_level_d;
      empty_q       <= empty_d;
      ae_q          <= (rd_level_q <= AE_LIM);
      unf_q         <= unf_d;
      rd_valid_q    <= rd_pop;
      if (rd_pop) dout_q <= rd_word[DATA_WIDTH-1:0];
`ifdef BOREAL_CDC_FIFO_PARITY_EN
      // Stored bit makes the whole word even; any odd result is a flip.
      rd_parity_err <= rd_pop && (^rd_word);
`endif
    end
  end

  assign full         = full_q;
  assign almost_full  = af_q;
  assign wr_level     = wr_level_q;
  assign wr_overflow  = ovf_q;
  assign dout         = dout_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = rd_level_q;
  assign rd_underflow = unf_q;

`ifndef SYNTHESIS
  // Both domains must be reset together; a lone domain reset corrupts pointers.
  always_comb begin
    assert (wr_rst_n == rd_rst_n)
      else $error("boreal_cdc_fifo: single-domain reset is unsupported");
  end
`endif

endmodule

// File: tb/tb_boreal_cdc_fifo.sv
module tb_boreal_cdc_fifo;
  localparam int DW = 792;
  localparam int AW = 4;
  localparam int SS = 2;
  localparam int PW = AW + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          perr;
  } exp_t;

  logic          wr_clk = 1'b0, rd_clk = 1'b0;
  logic          wr_rst_n = 1'b0, rd_rst_n = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, wr_clr_err = 1'b0, rd_clr_err = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full, almost_full, wr_overflow, rd_valid, empty, almost_empty, rd_underflow;
  logic [PW-1:0] wr_level, rd_level;
  logic [DW-1:0] dout;
`ifdef BOREAL_CDC_FIFO_PARITY_EN
  logic          rd_parity_err;
`endif

  int   rd_half = 5;
  int   n_checks = 0, n_errors = 0, n_valid = 0;
  int   n_wr = 0, n_rd = 0;
  bit   soak_on = 1'b0;
  exp_t exp_q[$];
  exp_t sb_e;

  always #10 wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  boreal_cdc_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS), .AF_THRESH(12), .AE_THRESH(2)
  ) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .wr_overflow(wr_overflow), .wr_clr_err(wr_clr_err),
    .rd_en(rd_en), .dout(dout), .rd_valid(rd_valid), .empty(empty),
    .almost_empty(almost_empty), .rd_level(rd_level), .rd_underflow(rd_underflow),
`ifdef BOREAL_CDC_FIFO_PARITY_EN
    .rd_parity_err(rd_parity_err),
`endif
    .rd_clr_err(rd_clr_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int s);
    logic [DW-1:0] w;
    w = '0;
    w[31:0] = s * 32'h9E3779B1;
    w[DW-1 -: 32] = s;
    return w;
  endfunction

  // One write cycle; the caller states whether the word is expected to be stored.
  task automatic wr_one(input logic [DW-1:0] d, input bit accept, input bit perr);
    wr_en = 1'b1;
    din   = d;
    if (accept) exp_q.push_back('{d, perr});
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Pop n words, issuing rd_en only while not empty; bounded.
  task automatic rd_n(input int n);
    int got = 0;
    int guard = 0;
    @(posedge rd_clk);
    #1;
    while (got < n && guard < 200) begin
      rd_en = !empty;
      @(posedge rd_clk);
      if (rd_en) got++;
      #1;
      guard++;
    end
    rd_en = 1'b0;
    chk("rd_n_count", 64'(got), 64'(n));
  endtask

  task automatic soak_writer(input int n, input int pct);
    int i = 0;
    int guard = 0;
    @(posedge wr_clk);
    #1;
    while (i < n && guard < 20000) begin
      if (!full && $urandom_range(0, 99) < pct) begin
        wr_en = 1'b1;
        din   = mk_word(n_wr + 1000);
        exp_q.push_back('{din, 1'b0});
      end else begin
        wr_en = 1'b0;
      end
      @(posedge wr_clk);
      if (wr_en) begin
        i++;
        n_wr++;
      end
      #1;
      guard++;
    end
    wr_en = 1'b0;
    chk("soak_wr_count", 64'(i), 64'(n));
  endtask

  task automatic soak_reader(input int n, input int pct);
    int got = 0;
    int guard = 0;
    @(posedge rd_clk);
    #1;
    while (got < n && guard < 20000) begin
      rd_en = (!empty && $urandom_range(0, 99) < pct);
      @(posedge rd_clk);
      if (rd_en) begin
        got++;
        n_rd++;
      end
      #1;
      guard++;
    end
    rd_en = 1'b0;
    chk("soak_rd_count", 64'(got), 64'(n));
  endtask

  // Scoreboard monitor: compare every delivered word with the oldest expected one.
  always @(negedge rd_clk) begin
    if (rd_valid) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got %0h, required no output", dout[63:0]);
      end else begin
        sb_e = exp_q.pop_front();
        if (dout !== sb_e.d) begin
          n_errors++;
          $display("FAIL sb_data: got %0h, required %0h", dout[63:0], sb_e.d[63:0]);
        end
`ifdef BOREAL_CDC_FIFO_PARITY_EN
        n_checks++;
        if (rd_parity_err !== sb_e.perr) begin
          n_errors++;
          $display("FAIL sb_parity: got %0b, required %0b", rd_parity_err, sb_e.perr);
        end
`endif
      end
    end
  end

  // Write-side level must never be below true occupancy.
  always @(negedge wr_clk) begin
    if (soak_on) begin
      n_checks++;
      if (int'(wr_level) < n_wr - n_rd) begin
        n_errors++;
        $display("FAIL wr_level_bound: got %0d, required >= %0d", wr_level, n_wr - n_rd);
      end
    end
  end

  // Read-side level must never exceed true occupancy.
  always @(negedge rd_clk) begin
    if (soak_on) begin
      n_checks++;
      if (int'(rd_level) > n_wr - n_rd) begin
        n_errors++;
        $display("FAIL rd_level_bound: got %0d, required <= %0d", rd_level, n_wr - n_rd);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset and reset-state check
    repeat (3) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    rd_rst_n = 1'b1;
    repeat (2) @(posedge wr_clk);
    #1;
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_wr_level", 64'(wr_level), 64'd0);
    chk("rst_ovf", 64'(wr_overflow), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ae", 64'(almost_empty), 64'd1);
    chk("rst_rd_level", 64'(rd_level), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_dout", dout[63:0], 64'd0);
    chk("rst_unf", 64'(rd_underflow), 64'd0);

    // Fill to full: words 0x1..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_one(DW'(i), 1'b1, 1'b0);
      if (i == 12) begin
        chk("lvl_at_12", 64'(wr_level), 64'd12);
        chk("af_lags_level", 64'(almost_full), 64'd0);
      end
      if (i == 13) chk("af_set", 64'(almost_full), 64'd1);
      if (i == 15) chk("not_full_15", 64'(full), 64'd0);
    end
    chk("full_16", 64'(full), 64'd1);
    chk("lvl_16", 64'(wr_level), 64'd16);
    wr_one(DW'(17), 1'b0, 1'b0);
    chk("ovf_set", 64'(wr_overflow), 64'd1);
    chk("lvl_after_ovf", 64'(wr_level), 64'd16);
    wr_clr_err = 1'b1;
    wr_one(DW'(18), 1'b0, 1'b0);
    chk("ovf_set_wins", 64'(wr_overflow), 64'd1);
    @(posedge wr_clk);
    #1;
    wr_clr_err = 1'b0;
    chk("ovf_cleared", 64'(wr_overflow), 64'd0);

    // Drain with rd_en held high
    repeat (4) @(posedge rd_clk);
    #1;
    chk("rd_level_16", 64'(rd_level), 64'd16);
    chk("ae_clear", 64'(almost_empty), 64'd0);
    rd_en = 1'b1;
    k = 0;
    while (k < 40) begin
      @(posedge rd_clk);
      #1;
      k++;
      if (empty) break;
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_rd_level", 64'(rd_level), 64'd0);
    @(posedge rd_clk);
    #1;
    chk("unf_set", 64'(rd_underflow), 64'd1);
    chk("no_valid_on_unf", 64'(rd_valid), 64'd0);
    chk("dout_held", dout[63:0], 64'h10);
    chk("drain_count", 64'(n_valid), 64'd16);
    rd_clr_err = 1'b1;
    @(posedge rd_clk);
    #1;
    chk("unf_set_wins", 64'(rd_underflow), 64'd1);
    rd_en = 1'b0;
    @(posedge rd_clk);
    #1;
    rd_clr_err = 1'b0;
    chk("unf_cleared", 64'(rd_underflow), 64'd0);
    repeat (6) @(posedge wr_clk);
    #1;
    chk("full_released", 64'(full), 64'd0);
    chk("wr_level_zero", 64'(wr_level), 64'd0);

    // Single write crossing latency
    wr_one(DW'(8'hA5), 1'b1, 1'b0);
    k = 0;
    while (empty && k < 8) begin
      @(posedge rd_clk);
      #1;
      k++;
    end
    n_checks++;
    if (empty || k > SS + 2) begin
      n_errors++;
      $display("FAIL vis_latency: got %0d rd edges, required <= %0d", k, SS + 2);
    end
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en = 1'b0;
    chk("a5_valid", 64'(rd_valid), 64'd1);
    chk("a5_dout", dout[63:0], 64'hA5);

    // Reset mid-stream with 8 entries held
    for (int i = 0; i < 8; i++) wr_one(DW'(32'h100 + i), 1'b0, 1'b0);
    chk("lvl_8", 64'(wr_level), 64'd8);
    repeat (6) @(posedge rd_clk);
    #1;
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    #2;
    chk("mrst_full", 64'(full), 64'd0);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_wr_level", 64'(wr_level), 64'd0);
    chk("mrst_rd_level", 64'(rd_level), 64'd0);
    chk("mrst_ae", 64'(almost_empty), 64'd1);
    chk("mrst_dout", dout[63:0], 64'd0);
    repeat (4) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    rd_rst_n = 1'b1;
    repeat (2) @(posedge wr_clk);
    #1;
    chk("post_rst_empty", 64'(empty), 64'd1);
    wr_one(DW'(8'h5A), 1'b1, 1'b0);
    rd_n(1);
    repeat (2) @(posedge rd_clk);

`ifdef BOREAL_CDC_FIFO_PARITY_EN
    // Corrupt the parity column of physical entry 3 (fourth slot after reset)
    @(posedge wr_clk);
    #1;
    for (int i = 1; i <= 4; i++) wr_one(DW'(32'hC0 + i), 1'b1, (i == 3));
    dut.mem_q[3][DW] = ~dut.mem_q[3][DW];
    rd_n(4);
    repeat (2) @(posedge rd_clk);
`endif

    // Wrap-around soak, 1:2 then 1:0.7 clock ratio
    n_wr = 0;
    n_rd = 0;
    soak_on = 1'b1;
    fork
      soak_writer(300, 75);
      soak_reader(300, 25);
    join
    rd_half = 14;
    fork
      soak_writer(300, 75);
      soak_reader(300, 75);
    join
    soak_on = 1'b0;
    repeat (4) @(posedge rd_clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("soak_no_unf", 64'(rd_underflow), 64'd0);
    chk("soak_no_ovf", 64'(wr_overflow), 64'd0);
    chk("soak_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
